// File: rtl/sprite_motion_ctrl_if.sv
// Move handshake between the sprite motion controller and the erase/draw FSM.
// The master raises move_req with old/new coordinates held stable until move_ack.
interface sprite_motion_ctrl_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           move_req;
  logic           move_ack;
  logic [X_W-1:0] old_x;
  logic [Y_W-1:0] old_y;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;

  modport master (output move_req, old_x, old_y, x, y, input move_ack);
  modport slave  (input move_req, old_x, old_y, x, y, output move_ack);
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Tick divider plus two-axis clamp/wrap sprite position with a req/ack move handshake.
// move_req rises one cycle after the tick; ticks arriving while a move is pending are dropped.
module sprite_motion_ctrl #(
  parameter int CLK_HZ = 50000000,
  parameter int TPS_W  = 32,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int STEP_W = 4,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 159,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = 119,
  parameter int X_INIT = 80,
  parameter int Y_INIT = 100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [TPS_W-1:0]  tps,
  input  logic [STEP_W-1:0] step,
  input  logic              wrap_mode,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_up,
  input  logic              btn_down,
  output logic              tick_out,
  output logic              tick_dropped,
  sprite_motion_ctrl_if.master mv
);

  localparam logic [TPS_W-1:0] CLK_HZ_V = TPS_W'(CLK_HZ);
  localparam logic [TPS_W-1:0] ONE      = TPS_W'(1);

  localparam logic [X_W:0] XMIN_E  = (X_W+1)'(X_MIN);
  localparam logic [X_W:0] XMAX_E  = (X_W+1)'(X_MAX);
  localparam logic [X_W:0] XSPAN_E = (X_W+1)'(X_MAX - X_MIN + 1);
  localparam logic [Y_W:0] YMIN_E  = (Y_W+1)'(Y_MIN);
  localparam logic [Y_W:0] YMAX_E  = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0] YSPAN_E = (Y_W+1)'(Y_MAX - Y_MIN + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [TPS_W-1:0] cnt;
  logic [TPS_W-1:0] quot;
  logic [TPS_W-1:0] limit_m1;

  // A quotient of 0 (tps above CLK_HZ) behaves as LIMIT=1, i.e. a tick every cycle.
  always_comb begin
    quot     = CLK_HZ_V / ((tps == '0) ? ONE : tps);
    limit_m1 = (quot == '0) ? '0 : quot - ONE;
  end

  always_ff @(posedge clock) begin
    if (reset || tps == '0) begin
      cnt      <= '0;
      tick_out <= 1'b0;
    end else if (cnt >= limit_m1) begin
      cnt      <= '0;
      tick_out <= 1'b1;
    end else begin
      cnt      <= cnt + ONE;
      tick_out <= 1'b0;
    end
  end

  logic [X_W:0]   x_e, xs_e, x_up, x_res;
  logic [Y_W:0]   y_e, ys_e, y_up, y_res;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;

  // Decrement underflow is detected before subtracting so the W+1 result never borrows.
  always_comb begin
    x_e   = {1'b0, mv.x};
    xs_e  = (X_W+1)'(step);
    x_up  = x_e + xs_e;
    x_res = x_e;
    if (btn_right && !btn_left)
      x_res = (x_up > XMAX_E) ? (wrap_mode ? x_up - XSPAN_E : XMAX_E) : x_up;
    else if (btn_left && !btn_right)
      x_res = (x_e < XMIN_E + xs_e) ? (wrap_mode ? x_e + XSPAN_E - xs_e : XMIN_E) : x_e - xs_e;
    nx = X_W'(x_res);

    y_e   = {1'b0, mv.y};
    ys_e  = (Y_W+1)'(step);
    y_up  = y_e + ys_e;
    y_res = y_e;
    if (btn_down && !btn_up)
      y_res = (y_up > YMAX_E) ? (wrap_mode ? y_up - YSPAN_E : YMAX_E) : y_up;
    else if (btn_up && !btn_down)
      y_res = (y_e < YMIN_E + ys_e) ? (wrap_mode ? y_e + YSPAN_E - ys_e : YMIN_E) : y_e - ys_e;
    ny = Y_W'(y_res);
  end

  logic [0:0] state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      mv.move_req  <= 1'b0;
      tick_dropped <= 1'b0;
      mv.x         <= X_W'(X_INIT);
      mv.old_x     <= X_W'(X_INIT);
      mv.y         <= Y_W'(Y_INIT);
      mv.old_y     <= Y_W'(Y_INIT);
    end else begin
      tick_dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (tick_out && (nx != mv.x || ny != mv.y)) begin
            mv.old_x    <= mv.x;
            mv.old_y    <= mv.y;
            mv.x        <= nx;
            mv.y        <= ny;
            mv.move_req <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          tick_dropped <= tick_out;
          if (mv.move_ack) begin
            mv.move_req <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: stimulus queues expected moves, drops and ticks;
// a monitor pops and compares them whenever the DUT presents one.
module tb_sprite_motion_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] tps;
  logic [3:0]  step;
  logic        wrap_mode;
  logic        btn_left, btn_right, btn_up, btn_down;
  logic        tick_out, tick_dropped;

  always #5 clock = ~clock;

  sprite_motion_ctrl_if #(.X_W(8), .Y_W(7)) mv ();

  sprite_motion_ctrl #(.CLK_HZ(100)) u_dut (
    .clock        (clock),
    .reset        (reset),
    .tps          (tps),
    .step         (step),
    .wrap_mode    (wrap_mode),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .tick_out     (tick_out),
    .tick_dropped (tick_dropped),
    .mv           (mv)
  );

  typedef struct {int ox; int oy; int nx; int ny;} mv_t;
  typedef struct {int nx; int ox;} drop_t;

  mv_t   exp_mv[$];
  drop_t exp_drop[$];
  int    exp_tick[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    ticks_seen = 0;
  bit    tick_chk = 1'b0;

  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic bad(input string name, input int act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0d, expected no such event", name, act);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    bit    prev_req = 1'b0;
    mv_t   m;
    drop_t d;
    forever begin
      @(posedge clock);
      #1;
      if (tick_out) begin
        ticks_seen++;
        if (tick_chk) begin
          if (exp_tick.size() == 0) bad("tick_extra", cyc);
          else chk("tick_cycle", cyc, exp_tick.pop_front());
        end
      end
      if (mv.move_req && !prev_req) begin
        if (exp_mv.size() == 0) bad("move_unexpected_x", int'(mv.x));
        else begin
          m = exp_mv.pop_front();
          chk("move_old_x", int'(mv.old_x), m.ox);
          chk("move_old_y", int'(mv.old_y), m.oy);
          chk("move_x", int'(mv.x), m.nx);
          chk("move_y", int'(mv.y), m.ny);
        end
      end
      if (tick_dropped) begin
        if (exp_drop.size() == 0) bad("drop_unexpected_x", int'(mv.x));
        else begin
          d = exp_drop.pop_front();
          chk("drop_x", int'(mv.x), d.nx);
          chk("drop_old_x", int'(mv.old_x), d.ox);
          chk("drop_req_held", int'(mv.move_req), 1);
        end
      end
      prev_req = mv.move_req;
    end
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mv.move_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bad("req_timeout", 0);
  endtask

  task automatic move(input logic l, input logic r, input logic u, input logic d,
                      input int ox, input int oy, input int nx, input int ny,
                      input int ack_dly, input bit hold);
    bit ok;
    exp_mv.push_back('{ox, oy, nx, ny});
    {btn_left, btn_right, btn_up, btn_down} = {l, r, u, d};
    wait_req(ok);
    if (!hold) {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
    if (ok) begin
      repeat (ack_dly) @(negedge clock);
      mv.move_ack = 1'b1;
      @(negedge clock);
      mv.move_ack = 1'b0;
      chk("req_fall", int'(mv.move_req), 0);
    end
  endtask

  initial begin
    bit ok;
    reset = 1'b1; tps = 32'd10; step = 4'd5; wrap_mode = 1'b0;
    {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
    mv.move_ack = 1'b0;
    exp_tick.push_back(10); exp_tick.push_back(20); exp_tick.push_back(30);
    tick_chk = 1'b1;
    repeat (3) @(negedge clock);

    chk("rst_tick_out", int'(tick_out), 0);
    chk("rst_tick_dropped", int'(tick_dropped), 0);
    chk("rst_move_req", int'(mv.move_req), 0);
    chk("rst_x", int'(mv.x), 80);
    chk("rst_y", int'(mv.y), 100);
    chk("rst_old_x", int'(mv.old_x), 80);
    chk("rst_old_y", int'(mv.old_y), 100);
    reset = 1'b0;

    while (cyc < 35) @(negedge clock);
    tick_chk = 1'b0;
    chk("idle_x", int'(mv.x), 80);
    chk("idle_y", int'(mv.y), 100);
    chk("idle_req", int'(mv.move_req), 0);

    move(0, 1, 0, 0, 80, 100, 85, 100, 3, 0);
    move(0, 1, 0, 0, 85, 100, 90, 100, 3, 0);
    step = 4'd15;
    move(0, 1, 0, 0, 90, 100, 105, 100, 3, 0);
    move(0, 1, 0, 0, 105, 100, 120, 100, 3, 0);
    move(0, 1, 0, 0, 120, 100, 135, 100, 3, 0);
    move(0, 1, 0, 0, 135, 100, 150, 100, 3, 0);
    step = 4'd7;
    move(0, 1, 0, 0, 150, 100, 157, 100, 3, 0);

    // Clamp at X_MAX, then the held button must produce no further request.
    step = 4'd5;
    move(0, 1, 0, 0, 157, 100, 159, 100, 3, 1);
    repeat (25) @(negedge clock);
    chk("clamp_hold_x", int'(mv.x), 159);
    chk("clamp_hold_req", int'(mv.move_req), 0);

    {btn_left, btn_right} = 2'b11;
    repeat (25) @(negedge clock);
    chk("both_lr_x", int'(mv.x), 159);
    chk("both_lr_req", int'(mv.move_req), 0);
    {btn_left, btn_right} = 2'b00;

    wrap_mode = 1'b1; step = 4'd3;
    move(0, 1, 0, 0, 159, 100, 2, 100, 3, 0);
    step = 4'd5;
    move(1, 0, 0, 0, 2, 100, 157, 100, 3, 0);
    step = 4'd15;
    move(0, 0, 0, 1, 157, 100, 157, 115, 3, 0);
    step = 4'd3;
    move(0, 0, 0, 1, 157, 115, 157, 118, 3, 0);
    move(0, 0, 0, 1, 157, 118, 157, 1, 3, 0);

    wrap_mode = 1'b0; step = 4'd5;
    move(1, 0, 1, 0, 157, 1, 152, 0, 3, 0);

    // Ack withheld across two ticks: both are dropped, outputs stay put.
    step = 4'd2;
    exp_drop.push_back('{154, 152});
    exp_drop.push_back('{154, 152});
    move(0, 1, 0, 0, 152, 0, 154, 0, 25, 0);
    chk("after_drop_x", int'(mv.x), 154);
    chk("after_drop_old_x", int'(mv.old_x), 152);

    tps = 32'd0;
    btn_right = 1'b1;
    repeat (2) @(negedge clock);
    ticks_seen = 0;
    repeat (40) @(negedge clock);
    chk("tps0_ticks", ticks_seen, 0);
    chk("tps0_x", int'(mv.x), 154);
    btn_right = 1'b0;
    tps = 32'd10;

    step = 4'd1;
    exp_mv.push_back('{154, 0, 155, 0});
    btn_right = 1'b1;
    wait_req(ok);
    btn_right = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_req_move_req", int'(mv.move_req), 0);
    chk("rst_req_x", int'(mv.x), 80);
    chk("rst_req_y", int'(mv.y), 100);
    chk("rst_req_old_x", int'(mv.old_x), 80);
    reset = 1'b0;
    repeat (25) @(negedge clock);
    chk("post_rst_req", int'(mv.move_req), 0);

    chk("mv_queue_left", exp_mv.size(), 0);
    chk("drop_queue_left", exp_drop.size(), 0);
    chk("tick_queue_left", exp_tick.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
